pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter and instruction-fetch sequencer for the Hack CPU. Owns the 16-bit PC register and drives the shared `inc16` incrementer to advance it. Runs a request/acknowledge handshake with instruction ROM and presents each fetched word to the CPU core with a valid/ready handshake. Applies jump targets, halt requests and a fetch-timeout guard.

## Interface
- `WIDTH`, 16, address/instruction word width (fixed at 16 for Hack)
- `RESET_VECTOR`, 16'h0000, PC value loaded on reset
- `MAX_WAIT`, 15, max cycles in FETCH without `rom_ack` before timeout (1..255)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rom_addr`  out  16  fetch address; equals `pc` while `rom_req`=1
- `rom_req`  out  1  fetch request; high only in FETCH
- `rom_ack`  in  1  ROM has `rom_data` valid this cycle
- `rom_data`  in  16  instruction word from ROM
- `instr`  out  16  registered instruction presented to core
- `instr_valid`  out  1  `instr` valid; high only in ISSUE
- `instr_ready`  in  1  core accepts `instr` this cycle
- `jump`  in  1  taken branch; sampled only on accept
- `jump_addr`  in  16  branch target; sampled only on accept
- `halt`  in  1  stop fetching (level)
- `pc`  out  16  current PC register
- `wrap`  out  1  one-cycle pulse: PC advanced FFFF→0000 by increment
- `fetch_err`  out  1  sticky fetch-timeout flag

## Operation
- Clock is `clk`. Reset is `reset`: one clock; asynchronous; active-high.
- States: IDLE, FETCH, ISSUE, HALTED.
- Reset (async, any state, mid-handshake included): state=IDLE, `pc`=RESET_VECTOR, `instr`=0, `instr_valid`=0, `rom_req`=0, `wrap`=0, `fetch_err`=0, wait counter=0. Pending ROM transaction is abandoned.
- IDLE: `halt`=1 → HALTED, else → FETCH.
- FETCH: `rom_req`=1, `rom_addr`=`pc`. On `rom_ack`, `instr`←`rom_data`, clear wait counter, → ISSUE. Without ack, increment wait counter. When counter reaches MAX_WAIT: set `fetch_err`, → HALTED. `halt` is ignored in FETCH so an outstanding request always completes or times out.
- ISSUE: `instr_valid`=1, `instr` stable until accept. Accept = `instr_valid` & `instr_ready`. On accept:
  - `pc` ← `jump` ? `jump_addr` : `inc16(pc)`.
  - If `halt`=1 → HALTED, else → FETCH.
- HALTED: outputs idle, `pc` held. When `halt`=0 → FETCH and refetch at current `pc`. `fetch_err` stays set until reset.
- Arithmetic: increment is modulo 2^16 and is taken only from the `inc16` output. `wrap` pulses in the cycle after an accept that increments `pc` from FFFF to 0000. A jump to 0000 does not pulse `wrap`.
- Ignored inputs: `rom_ack` outside FETCH; `instr_ready`, `jump` and `jump_addr` outside an accept.

## Timing
- IDLE lasts exactly 1 cycle after reset release.
- Best case is 2 cycles per instruction: FETCH with `rom_ack` in the same cycle, then ISSUE with `instr_ready` in the same cycle.
- `rom_ack` at edge N puts `instr`/`instr_valid` at N+1.
- Accept at edge N updates `pc`/`rom_addr` at N+1, and `rom_req` rises in the same cycle (N+1).
- Timeout: with no ack, `fetch_err` rises on the MAX_WAIT-th FETCH cycle edge; `rom_req` drops the following cycle.
- `halt` change at accept: takes effect at that same edge. `halt` deassert in HALTED: FETCH on the next edge.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Structure
- Shared package `hack_pkg`: `WORD_W`=16, `pc_state_t` enum {IDLE, FETCH, ISSUE, HALTED}, default `RESET_VECTOR`.
- One sub-module: the existing `inc16`, instantiated once, input `pc`, output feeding the PC next-state mux.
- Everything else is a single FSM plus the PC, instr, wait-counter and flag registers.

## Test plan
- Reset, `halt`=0, ROM acks immediately, core always ready → `rom_addr` 0000,0001,0002… on alternating cycles; `instr` matches ROM contents; 2 cycles/instr.
- ROM ack delayed 3 cycles; core ready delayed 2 cycles at addr 0005 → `rom_req` held 4 cycles; `instr` held stable; `pc` stays 0005 until accept, then 0006.
- Accept at `pc`=0010 with `jump`=1, `jump_addr`=0x1234 → next `rom_addr`=0x1234, no `wrap`. Repeat at `pc`=FFFF with `jump`=0 → `pc`=0000, `wrap` one-cycle pulse.
- `halt`=1 during accept at 0020 → HALTED, `pc`=0021, `rom_req`=0 for 10 cycles. Release → fetch at 0021.
- No `rom_ack` with MAX_WAIT=15 → `fetch_err`=1 after 15 FETCH cycles, state HALTED, `pc` unchanged. Drop `halt` → refetch at same `pc`, `fetch_err` still 1.
- Assert `reset` mid-ISSUE and mid-FETCH → all outputs to reset values immediately; `pc`=RESET_VECTOR; first fetch 2 cycles after release.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: word width, fetch-sequencer state encoding and
// the default program-counter reset vector.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_VECTOR = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } pc_state_t;

endpackage

// File: rtl/inc16.sv
// Hack 16-bit incrementer: out = in + 1, modulo 2^16.
module inc16
    import hack_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    output logic [WORD_W-1:0] out
);

    assign out = in + {{(WORD_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Hack program counter and instruction-fetch sequencer: ROM req/ack on one side,
// instr valid/ready toward the core, with jump, halt and fetch-timeout handling.
module pc_fetch_ctrl
    import hack_pkg::*;
#(
    parameter int                WIDTH        = WORD_W,
    parameter logic [WORD_W-1:0] RESET_VECTOR = hack_pkg::RESET_VECTOR,
    parameter int                MAX_WAIT     = 15
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] rom_addr,
    output logic             rom_req,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             fetch_err
);

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    pc_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIDTH-1:0]  pc_inc;

    inc16 u_inc16 (
        .in  (pc),
        .out (pc_inc)
    );

    // Handshake outputs decode straight from state, so no input reaches an output combinationally.
    assign rom_req     = (state == FETCH);
    assign instr_valid = (state == ISSUE);
    assign rom_addr    = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_VECTOR;
            instr     <= '0;
            wrap      <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    state <= halt ? HALTED : FETCH;
                end
                // halt is deliberately not looked at here: a request in flight must finish or time out.
                FETCH: begin
                    if (rom_ack) begin
                        instr    <= rom_data;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        pc    <= jump ? jump_addr : pc_inc;
                        wrap  <= ~jump & (pc_inc == '0);
                        state <= halt ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: table of fetch/issue transactions with a ROM-word
// scoreboard, plus hand sequences for halt, timeout and asynchronous reset.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [15:0] jump_addr;
    logic        halt;
    logic [15:0] pc;
    logic        wrap;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_pc;
    logic [15:0] exp_q[$];

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        logic        jmp;
        logic [15:0] jaddr;
        logic [15:0] exp_pc;
        logic        exp_wrap;
    } vec_t;

    vec_t tbl[11];

    pc_fetch_ctrl #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000),
        .MAX_WAIT     (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .pc          (pc),
        .wrap        (wrap),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk16({tag, "_pc"}, pc, 16'h0000);
        chk16({tag, "_rom_addr"}, rom_addr, 16'h0000);
        chk16({tag, "_instr"}, instr, 16'h0000);
        chk1({tag, "_valid"}, instr_valid, 1'b0);
        chk1({tag, "_req"}, rom_req, 1'b0);
        chk1({tag, "_wrap"}, wrap, 1'b0);
        chk1({tag, "_err"}, fetch_err, 1'b0);
    endtask

    // Starts at a negedge with the DUT in its first FETCH cycle; ends one cycle after the accept.
    task automatic do_instr(input vec_t v, input logic h);
        int          reqs;
        logic [15:0] held;
        chk1("fetch_req", rom_req, 1'b1);
        chk16("fetch_addr", rom_addr, model_pc);
        reqs = 1;
        for (int k = 0; k < v.ack_dly; k++) begin
            rom_ack     = 1'b0;
            rom_data    = 16'($urandom);
            instr_ready = 1'b1;
            cyc();
            if (rom_req) reqs++;
        end
        rom_ack     = 1'b1;
        rom_data    = rom_word(model_pc);
        instr_ready = 1'b0;
        exp_q.push_back(rom_word(model_pc));
        cyc();
        rom_ack = 1'b0;
        chk16("req_cycles", 16'(reqs), 16'(v.ack_dly + 1));
        chk1("issue_valid", instr_valid, 1'b1);
        chk1("issue_req_low", rom_req, 1'b0);
        chk1("wrap_one_cycle", wrap, 1'b0);
        held = exp_q.pop_front();
        for (int k = 0; k < v.rdy_dly; k++) begin
            instr_ready = 1'b0;
            jump        = 1'b1;
            jump_addr   = 16'($urandom);
            rom_ack     = 1'b1;
            rom_data    = 16'($urandom);
            cyc();
            chk16("instr_hold", instr, held);
            chk16("pc_hold", pc, model_pc);
            chk1("valid_hold", instr_valid, 1'b1);
        end
        rom_ack = 1'b0;
        chk16("instr", instr, held);
        instr_ready = 1'b1;
        jump        = v.jmp;
        jump_addr   = v.jaddr;
        halt        = h;
        cyc();
        instr_ready = 1'b0;
        jump        = 1'b0;
        chk16("pc_next", pc, v.exp_pc);
        chk1("wrap", wrap, v.exp_wrap);
        chk1("req_after_accept", rom_req, ~h);
        chk1("valid_after_accept", instr_valid, 1'b0);
        if (!h) chk16("addr_after_accept", rom_addr, v.exp_pc);
        model_pc = v.exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        tbl[0]  = '{0, 0, 1'b0, 16'h0000, 16'h0001, 1'b0};
        tbl[1]  = '{0, 0, 1'b0, 16'h0000, 16'h0002, 1'b0};
        tbl[2]  = '{0, 0, 1'b1, 16'h0005, 16'h0005, 1'b0};
        tbl[3]  = '{3, 2, 1'b0, 16'h0000, 16'h0006, 1'b0};
        tbl[4]  = '{1, 0, 1'b1, 16'h0010, 16'h0010, 1'b0};
        tbl[5]  = '{0, 0, 1'b1, 16'h1234, 16'h1234, 1'b0};
        tbl[6]  = '{0, 1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        tbl[7]  = '{0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[8]  = '{2, 0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        tbl[9]  = '{0, 0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{1, 1, 1'b1, 16'h0020, 16'h0020, 1'b0};

        reset       = 1'b1;
        rom_ack     = 1'b0;
        rom_data    = 16'h0000;
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_addr   = 16'h0000;
        halt        = 1'b0;
        model_pc    = 16'h0000;

        cyc();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk1("idle_req", rom_req, 1'b0);
        cyc();

        for (int i = 0; i < 11; i++) do_instr(tbl[i], 1'b0);

        // Halt requested on the accept at 0020.
        v = '{0, 0, 1'b0, 16'h0000, 16'h0021, 1'b0};
        do_instr(v, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk1("halted_req", rom_req, 1'b0);
            chk16("halted_pc", pc, 16'h0021);
        end
        halt = 1'b0;
        cyc();
        chk1("release_req", rom_req, 1'b1);
        chk16("release_addr", rom_addr, 16'h0021);

        // Timeout: no ack for MAX_WAIT cycles; halt held high to show it is ignored in FETCH.
        halt = 1'b1;
        for (int k = 1; k < 15; k++) begin
            cyc();
            chk1("timeout_pending_err", fetch_err, 1'b0);
            chk1("timeout_pending_req", rom_req, 1'b1);
        end
        cyc();
        chk1("timeout_err", fetch_err, 1'b1);
        chk1("timeout_req", rom_req, 1'b0);
        chk16("timeout_pc", pc, 16'h0021);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk1("timeout_halted_req", rom_req, 1'b0);
        end
        halt = 1'b0;
        cyc();
        chk1("refetch_req", rom_req, 1'b1);
        chk16("refetch_addr", rom_addr, 16'h0021);
        chk1("err_sticky", fetch_err, 1'b1);
        v = '{0, 0, 1'b0, 16'h0000, 16'h0022, 1'b0};
        do_instr(v, 1'b0);
        chk1("err_sticky2", fetch_err, 1'b1);

        // Asynchronous reset in the middle of FETCH.
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_fetch");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rst_fetch_idle", rom_req, 1'b0);
        @(negedge clk);
        chk1("rst_fetch_first_req", rom_req, 1'b1);
        chk16("rst_fetch_first_addr", rom_addr, 16'h0000);

        // Asynchronous reset in the middle of ISSUE.
        rom_ack  = 1'b1;
        rom_data = rom_word(16'h0000);
        cyc();
        rom_ack = 1'b0;
        chk1("pre_rst_valid", instr_valid, 1'b1);
        chk16("pre_rst_instr", instr, rom_word(16'h0000));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_issue");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rst_issue_idle", rom_req, 1'b0);
        @(negedge clk);
        model_pc = 16'h0000;
        v = '{1, 0, 1'b0, 16'h0000, 16'h0001, 1'b0};
        do_instr(v, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
